// File: rtl/rle_encoder.sv
// Run-length encoder: merges a pixel stream and an audio stream into 20-bit words for the video decoder.
// Build option: define RLE_WORD_COUNT_EN to enable the word_count handshake counter (otherwise it reads 0).
module rle_encoder #(
  parameter int MAX_RUN = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pixel_valid,
  input  logic [8:0]  pixel_colour,
  input  logic        pixel_last,
  output logic        pixel_ready,
  input  logic        audio_valid,
  input  logic [7:0]  audio_sample,
  output logic        audio_ready,
  output logic [19:0] word_data,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [15:0] word_count
);

  localparam logic [9:0] LEN_MAX = 10'(MAX_RUN - 1);

  logic        run_active, run_active_next;
  logic [8:0]  run_colour, run_colour_next;
  logic [9:0]  run_len, run_len_next;
  logic        hold_valid, hold_valid_next;
  logic [19:0] hold_word, hold_word_next;
  logic        pending_last, pending_last_next;
  logic        abuf_valid;
  logic [7:0]  abuf_sample;
  logic        live;

  logic pix_acc, aud_acc, slot_free, load_audio, load_hold, hold_free, extend;

  // live keeps the inputs stalled until the first edge after reset release
  assign pixel_ready = live && !hold_valid && !pending_last;
  assign audio_ready = live && !abuf_valid;
  assign pix_acc     = pixel_valid && pixel_ready;
  assign aud_acc     = audio_valid && audio_ready;
  assign slot_free   = !word_valid || word_ready;
  assign load_audio  = slot_free && abuf_valid;
  assign load_hold   = slot_free && !abuf_valid && hold_valid;
  assign hold_free   = !hold_valid || load_hold;
  assign extend      = run_active && (pixel_colour == run_colour) && (run_len < LEN_MAX);

  always_comb begin
    run_active_next   = run_active;
    run_colour_next   = run_colour;
    run_len_next      = run_len;
    hold_valid_next   = hold_valid && !load_hold;
    hold_word_next    = hold_word;
    pending_last_next = pending_last;
    if (pending_last && hold_free) begin
      // single-pixel run left behind by a colour change on the last pixel
      hold_valid_next   = 1'b1;
      hold_word_next    = {1'b0, run_len, run_colour};
      run_active_next   = 1'b0;
      pending_last_next = 1'b0;
    end else if (pix_acc) begin
      if (extend) begin
        run_len_next = run_len + 10'd1;
        if (pixel_last) begin
          hold_valid_next = 1'b1;
          hold_word_next  = {1'b0, run_len + 10'd1, run_colour};
          run_active_next = 1'b0;
        end
      end else if (!run_active) begin
        run_colour_next = pixel_colour;
        run_len_next    = 10'd0;
        if (pixel_last) begin
          hold_valid_next = 1'b1;
          hold_word_next  = {1'b0, 10'd0, pixel_colour};
          run_active_next = 1'b0;
        end else begin
          run_active_next = 1'b1;
        end
      end else begin
        hold_valid_next   = 1'b1;
        hold_word_next    = {1'b0, run_len, run_colour};
        run_colour_next   = pixel_colour;
        run_len_next      = 10'd0;
        run_active_next   = 1'b1;
        pending_last_next = pixel_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live         <= 1'b0;
      run_active   <= 1'b0;
      run_colour   <= 9'd0;
      run_len      <= 10'd0;
      hold_valid   <= 1'b0;
      hold_word    <= 20'd0;
      pending_last <= 1'b0;
      abuf_valid   <= 1'b0;
      abuf_sample  <= 8'd0;
      word_valid   <= 1'b0;
      word_data    <= 20'd0;
    end else begin
      live         <= 1'b1;
      run_active   <= run_active_next;
      run_colour   <= run_colour_next;
      run_len      <= run_len_next;
      hold_valid   <= hold_valid_next;
      hold_word    <= hold_word_next;
      pending_last <= pending_last_next;
      if (load_audio) begin
        abuf_valid <= 1'b0;
      end
      if (aud_acc) begin
        abuf_valid  <= 1'b1;
        abuf_sample <= audio_sample;
      end
      if (load_audio) begin
        word_valid <= 1'b1;
        word_data  <= {1'b1, 11'd0, abuf_sample};
      end else if (load_hold) begin
        word_valid <= 1'b1;
        word_data  <= hold_word;
      end else if (slot_free) begin
        word_valid <= 1'b0;
      end
    end
  end

`ifdef RLE_WORD_COUNT_EN
  logic [15:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 16'd0;
    end else if (word_valid && word_ready) begin
      count <= count + 16'd1;
    end
  end

  assign word_count = count;
`else
  assign word_count = 16'd0;
`endif

endmodule

// File: tb/tb_rle_encoder.sv
// Self-checking bench for rle_encoder: directed cases plus a randomized run against a run-grouping model.
module tb_rle_encoder;
  localparam int MAXR = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pixel_valid = 1'b0;
  logic [8:0]  pixel_colour = 9'd0;
  logic        pixel_last = 1'b0;
  logic        pixel_ready;
  logic        audio_valid = 1'b0;
  logic [7:0]  audio_sample = 8'd0;
  logic        audio_ready;
  logic [19:0] word_data;
  logic        word_valid;
  logic        word_ready = 1'b1;
  logic [15:0] word_count;

  rle_encoder #(.MAX_RUN(MAXR)) dut (
    .clk(clk), .rst_n(rst_n),
    .pixel_valid(pixel_valid), .pixel_colour(pixel_colour), .pixel_last(pixel_last),
    .pixel_ready(pixel_ready),
    .audio_valid(audio_valid), .audio_sample(audio_sample), .audio_ready(audio_ready),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // output monitor: record handshaken words, valid cycles and stall stability
  logic [19:0] got_q[$];
  int          vcycles = 0;
  int          hs = 0;
  int          stall_viol = 0;
  bit          prev_stall = 1'b0;
  logic [19:0] prev_data = 20'd0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !(word_valid === 1'b1 && word_data === prev_data)) stall_viol++;
      if (word_valid) vcycles++;
      if (word_valid && word_ready) begin
        got_q.push_back(word_data);
        hs++;
      end
      prev_stall = word_valid && !word_ready;
      prev_data  = word_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_pix(input logic [8:0] c, input logic l);
    int   n = 0;
    logic done = 1'b0;
    pixel_valid = 1'b1; pixel_colour = c; pixel_last = l;
    while (!done && n < 200) begin
      @(negedge clk);
      if (pixel_ready) done = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    pixel_valid = 1'b0; pixel_last = 1'b0;
    chk("pix_accept", 32'(done), 32'd1);
  endtask

  task automatic send_aud(input logic [7:0] s);
    int   n = 0;
    logic done = 1'b0;
    audio_valid = 1'b1; audio_sample = s;
    while (!done && n < 200) begin
      @(negedge clk);
      if (audio_ready) done = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    audio_valid = 1'b0;
    chk("aud_accept", 32'(done), 32'd1);
  endtask

  task automatic wait_words(input string tag, input int n);
    int k = 0;
    while (got_q.size() < n && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk(tag, 32'(got_q.size()), 32'(n));
  endtask

  // reference: group equal consecutive colours of a line, split each group into MAXR chunks
  logic [8:0]  line_q[$];
  logic [19:0] exp_pix[$];
  logic [19:0] exp_aud[$];

  task automatic model_line();
    int i = 0;
    int j, len, chunk;
    while (i < line_q.size()) begin
      j = i;
      while (j < line_q.size() && line_q[j] == line_q[i]) j++;
      len = j - i;
      while (len > 0) begin
        chunk = (len > MAXR) ? MAXR : len;
        exp_pix.push_back({1'b0, 10'(chunk - 1), line_q[i]});
        len -= chunk;
      end
      i = j;
    end
  endtask

  logic [8:0] pix_col[$];
  logic       pix_lst[$];
  logic [7:0] aud_s[$];

  initial begin
    int base, vbase, hs_rst, pi, ai, nr, rl, ka, kp;
    logic [8:0] c;
    logic pacc, aacc;
    logic [19:0] w;

    // reset state
    #1;
    chk("rst_word_valid", 32'(word_valid), 32'd0);
    chk("rst_word_data", 32'(word_data), 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    hs_rst = hs;
    @(posedge clk); @(negedge clk);
    chk("rst_pixel_ready", 32'(pixel_ready), 32'd1);
    chk("rst_audio_ready", 32'(audio_ready), 32'd1);
    @(posedge clk); #1;

    // five pixels of 0x1FF closed by last -> one word, valid for one cycle
    base = got_q.size(); vbase = vcycles;
    for (int i = 0; i < 5; i++) send_pix(9'h1FF, i == 4);
    wait_words("t1_count", base + 1);
    chk("t1_word", 32'(got_q[base]), 32'h009FF);
    chk("t1_valid_cycles", 32'(vcycles - vbase), 32'd1);

    // A,A,B(last): old run then single-pixel run via pending close
    base = got_q.size();
    send_pix(9'h005, 1'b0);
    send_pix(9'h005, 1'b0);
    send_pix(9'h100, 1'b1);
    @(negedge clk);
    chk("t2_ready_drop", 32'(pixel_ready), 32'd0);
    wait_words("t2_count", base + 2);
    chk("t2_word0", 32'(got_q[base]), 32'h00205);
    chk("t2_word1", 32'(got_q[base + 1]), 32'h00100);

    // run-length limit: 10 pixels with MAX_RUN=8 -> 8 + 2
    base = got_q.size();
    for (int i = 0; i < 10; i++) send_pix(9'h0AA, i == 9);
    wait_words("t3_count", base + 2);
    chk("t3_word0", 32'(got_q[base]), 32'h00EAA);
    chk("t3_word1", 32'(got_q[base + 1]), 32'h002AA);

    // audio accepted on the same edge a run closes: audio word leaves first
    base = got_q.size();
    send_pix(9'h033, 1'b0);
    send_pix(9'h033, 1'b0);
    pixel_valid = 1'b1; pixel_colour = 9'h033; pixel_last = 1'b1;
    audio_valid = 1'b1; audio_sample = 8'h7E;
    @(negedge clk);
    chk("t4_both_ready", 32'({pixel_ready, audio_ready}), 32'd3);
    @(posedge clk); #1;
    pixel_valid = 1'b0; pixel_last = 1'b0; audio_valid = 1'b0;
    wait_words("t4_count", base + 2);
    chk("t4_word0", 32'(got_q[base]), 32'h8007E);
    chk("t4_word1", 32'(got_q[base + 1]), 32'h00433);

    // backpressure: three words pending, stall 10 cycles
    base = got_q.size();
    word_ready = 1'b0;
    send_aud(8'h11);
    send_pix(9'h0F0, 1'b1);
    send_aud(8'h22);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("t5_pixel_ready", 32'(pixel_ready), 32'd0);
    chk("t5_audio_ready", 32'(audio_ready), 32'd0);
    chk("t5_held_data", 32'(word_data), 32'h80011);
    @(posedge clk); #1;
    word_ready = 1'b1;
    wait_words("t5_count", base + 3);
    chk("t5_word0", 32'(got_q[base]), 32'h80011);
    chk("t5_word1", 32'(got_q[base + 1]), 32'h80022);
    chk("t5_word2", 32'(got_q[base + 2]), 32'h000F0);

    // asynchronous reset mid-run with a stalled output word
    word_ready = 1'b0;
    send_aud(8'h55);
    for (int i = 0; i < 3; i++) send_pix(9'h123, 1'b0);
    @(posedge clk); #2;
    chk("t6_valid_before", 32'(word_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_valid_async", 32'(word_valid), 32'd0);
    chk("t6_data_async", 32'(word_data), 32'd0);
    chk("t6_count_async", 32'(word_count), 32'd0);
    @(negedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    hs_rst = hs;
    word_ready = 1'b1;
    base = got_q.size();
    repeat (5) @(posedge clk);
    #1;
    chk("t6_no_stale", 32'(got_q.size()), 32'(base));
    send_pix(9'h123, 1'b1);
    wait_words("t6_count", base + 1);
    chk("t6_word", 32'(got_q[base]), 32'h00123);

    // randomized interleaving with random backpressure
    for (int l = 0; l < 30; l++) begin
      line_q.delete();
      nr = $urandom_range(1, 4);
      for (int r = 0; r < nr; r++) begin
        c  = 9'($urandom_range(0, 3) * 165);
        rl = $urandom_range(1, 20);
        for (int k = 0; k < rl; k++) line_q.push_back(c);
      end
      model_line();
      for (int k = 0; k < line_q.size(); k++) begin
        pix_col.push_back(line_q[k]);
        pix_lst.push_back(k == line_q.size() - 1);
      end
    end
    for (int k = 0; k < 60; k++) begin
      aud_s.push_back(8'($urandom_range(0, 255)));
      exp_aud.push_back({1'b1, 11'd0, aud_s[k]});
    end
    base = got_q.size();
    pi = 0; ai = 0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (pi == pix_col.size() && ai == aud_s.size() &&
          got_q.size() - base == exp_pix.size() + exp_aud.size()) break;
      pixel_valid = (pi < pix_col.size()) && ($urandom_range(0, 3) != 0);
      if (pi < pix_col.size()) begin
        pixel_colour = pix_col[pi];
        pixel_last   = pix_lst[pi];
      end
      audio_valid = (ai < aud_s.size()) && ($urandom_range(0, 7) == 0);
      if (ai < aud_s.size()) audio_sample = aud_s[ai];
      word_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      pacc = pixel_valid && pixel_ready;
      aacc = audio_valid && audio_ready;
      @(posedge clk); #1;
      if (pacc) pi++;
      if (aacc) ai++;
    end
    pixel_valid = 1'b0; pixel_last = 1'b0; audio_valid = 1'b0; word_ready = 1'b1;
    wait_words("rnd_count", base + exp_pix.size() + exp_aud.size());
    chk("rnd_pix_sent", 32'(pi), 32'(pix_col.size()));
    chk("rnd_aud_sent", 32'(ai), 32'(aud_s.size()));
    ka = 0; kp = 0;
    for (int k = base; k < got_q.size(); k++) begin
      w = got_q[k];
      if (w[19]) begin
        chk("rnd_audio", 32'(w), (ka < exp_aud.size()) ? 32'(exp_aud[ka]) : 32'hFFFFFFFF);
        ka++;
      end else begin
        chk("rnd_pixel", 32'(w), (kp < exp_pix.size()) ? 32'(exp_pix[kp]) : 32'hFFFFFFFF);
        kp++;
      end
    end

    chk("stall_stability", 32'(stall_viol), 32'd0);
`ifdef RLE_WORD_COUNT_EN
    chk("word_count", 32'(word_count), 32'((hs - hs_rst) & 16'hFFFF));
`else
    chk("word_count", 32'(word_count), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
